// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote, 5..9 data bits.
// Define UART_RX_PARITY_EN to build the optional parity bit (PARITY: 0 none, 1 odd, 2 even).
module uart_rx_param #(
    parameter int CLK_FREQ  = 40000,
    parameter int UART_BPS  = 1000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int CPB  = CLK_FREQ / UART_BPS;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_VOTE = CW'(HALF + 1);
    localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    localparam bit P = (PARITY != 0);
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam bit P = 1'b0 && (PARITY != 0);
`endif

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic                   rx_d_q, rx_d_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             samp_q, samp_d;
    logic                   stop_q, stop_d;
    logic                   fin_q, fin_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   dout_vld_q, dout_vld_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
    logic                   pbit_q, pbit_d;
`endif

    logic rx_s;
    logic vote;
    logic at_vote;
    logic at_end;

    assign rx_s    = sync_q[1];
    // Third sample is the live synchroniser output in the decision cycle.
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign at_vote = (cnt_q == C_VOTE);
    assign at_end  = (cnt_q == C_LAST);

    always_comb begin
        sync_d  = {sync_q[0], bit_in};
        rx_d_d  = rx_s;
        state_d = state_q;
        cnt_d   = at_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        if (cnt_q == C_S0) samp_d[0] = rx_s;
        if (cnt_q == C_S1) samp_d[1] = rx_s;
        stop_d  = stop_q;
        fin_d   = 1'b0;
        dout_d      = fin_q ? shift_q : dout_q;
        dout_vld_d  = fin_q;
        frame_err_d = fin_q & ~stop_q;
`ifdef UART_RX_PARITY_EN
        pbit_d       = pbit_q;
        parity_err_d = fin_q & P & ((^shift_q ^ pbit_q) != (PARITY == 1));
`else
        parity_err_d = P;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s) state_d = START;
            end
            START: begin
                if (at_vote && vote) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (at_vote) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 4'd1;
                end
                if (at_end && idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = P ? PAR : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PAR: begin
                if (at_vote) pbit_d = vote;
                if (at_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is never missed.
                if (at_vote) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                    stop_d  = vote;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            rx_d_q       <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            stop_q       <= 1'b0;
            fin_q        <= 1'b0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rx_d_q       <= rx_d_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            stop_q       <= stop_d;
            fin_q        <= fin_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= pbit_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit receiver (parity frames when UART_RX_PARITY_EN is set)
// plus a 5-bit receiver for back-to-back frames; expected words held in scoreboard queues.
module tb_uart_rx_param;
    localparam int CPB  = 40;
    localparam int HALF = 20;
`ifdef UART_RX_PARITY_EN
    localparam int TP = 1;
`else
    localparam int TP = 0;
`endif
    localparam int K8 = 1 + 8 + TP;
    localparam int K5 = 1 + 5;

    typedef struct {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        int         at;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx8, rx5;
    logic [7:0] dout8;
    logic [4:0] dout5;
    logic       vld8, fe8, pe8, vld5, fe5, pe5;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sb8[$];
    exp_t       sb5[$];

    uart_rx_param #(.CLK_FREQ(40000), .UART_BPS(1000), .DATA_BITS(8), .PARITY(2)) u_dut8 (
        .clk(clk), .rst(rst), .bit_in(rx8), .dout(dout8),
        .dout_vld(vld8), .frame_err(fe8), .parity_err(pe8)
    );

    uart_rx_param #(.CLK_FREQ(40000), .UART_BPS(1000), .DATA_BITS(5), .PARITY(0)) u_dut5 (
        .clk(clk), .rst(rst), .bit_in(rx5), .dout(dout5),
        .dout_vld(vld5), .frame_err(fe5), .parity_err(pe5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 8) rx8 = v;
        else rx5 = v;
    endtask

    // Drives one frame; bits at position >= len are replaced by idle-high.
    task automatic drive(input int sel, input logic [8:0] data, input int nd, input bit par,
                         input logic pbit, input logic stop, input int len);
        logic fb [0:11];
        int   n;
        for (int i = 0; i < 12; i++) fb[i] = 1'b1;
        fb[0] = 1'b0;
        for (int i = 0; i < nd; i++) fb[1+i] = data[i];
        n = 1 + nd;
        if (par) begin
            fb[n] = pbit;
            n++;
        end
        fb[n] = stop;
        n++;
        for (int i = 0; i < n; i++) begin
            set_line(sel, (i < len) ? fb[i] : 1'b1);
            repeat (CPB) @(posedge clk);
            #1;
        end
        set_line(sel, 1'b1);
    endtask

    task automatic check_pulse(input int sel, output int at);
        bit         found;
        exp_t       e;
        logic [8:0] d;
        found = 1'b0;
        at = -1;
        for (int n = 0; n < (K8 + 2) * CPB && !found; n++) begin
            @(negedge clk);
            if ((sel == 8) ? vld8 : vld5) begin
                found = 1'b1;
                at = cyc;
            end
        end
        chk($sformatf("vld%0d_seen", sel), 32'(found), 32'd1);
        if (sel == 8) e = sb8.pop_front();
        else e = sb5.pop_front();
        d = (sel == 8) ? {1'b0, dout8} : {4'b0, dout5};
        chk($sformatf("dout%0d", sel), 32'(d), 32'(e.data));
        chk($sformatf("frame_err%0d", sel), 32'((sel == 8) ? fe8 : fe5), 32'(e.fe));
        chk($sformatf("parity_err%0d", sel), 32'((sel == 8) ? pe8 : pe5), 32'(e.pe));
        chk($sformatf("latency%0d", sel), 32'(at), 32'(e.at));
        @(negedge clk);
        chk($sformatf("vld%0d_width", sel), 32'((sel == 8) ? vld8 : vld5), 32'd0);
        chk($sformatf("flags%0d_after", sel), 32'((sel == 8) ? {fe8, pe8} : {fe5, pe5}), 32'd0);
    endtask

    task automatic frame8(input logic [7:0] data, input logic pflip, input logic stop);
        exp_t e;
        int   at;
        e.data = {1'b0, data};
        e.fe   = ~stop;
        e.pe   = (TP == 1) ? pflip : 1'b0;
        e.at   = cyc + 6 + K8 * CPB + HALF;
        sb8.push_back(e);
        fork
            drive(8, {1'b0, data}, 8, (TP == 1), (^data) ^ pflip, stop, 99);
            check_pulse(8, at);
        join
    endtask

    initial begin
        int   cnt;
        int   at1, at2;
        exp_t e;
        rst = 1'b1;
        rx8 = 1'b1;
        rx5 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout8), 32'd0);
        chk("rst_vld", 32'(vld8), 32'd0);
        chk("rst_fe", 32'(fe8), 32'd0);
        chk("rst_pe", 32'(pe8), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        frame8(8'h55, 1'b0, 1'b1);
        frame8(8'hA3, 1'b0, 1'b1);
`ifdef UART_RX_PARITY_EN
        frame8(8'hA3, 1'b1, 1'b1);
`endif
        frame8(8'h3C, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);
        #1;
        frame8(8'h01, 1'b0, 1'b1);

        // False start: 5 low cycles must not produce a word.
        rx8 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx8 = 1'b1;
        cnt = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (vld8) cnt++;
        end
        chk("glitch_no_vld", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        frame8(8'h7E, 1'b0, 1'b1);

        // Reset in the middle of data bit 4; the remaining line stays idle-high.
        cnt = 0;
        fork
            drive(8, 9'h0F0, 8, (TP == 1), 1'b0, 1'b1, 6);
            begin
                repeat (5 * CPB + HALF) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_dout", 32'(dout8), 32'd0);
                chk("rst_mid_vld", 32'(vld8), 32'd0);
                chk("rst_mid_flags", 32'({fe8, pe8}), 32'd0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
            for (int n = 0; n < (K8 + 3) * CPB; n++) begin
                @(negedge clk);
                if (vld8) cnt++;
            end
        join
        chk("rst_no_vld", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        frame8(8'hC3, 1'b0, 1'b1);

        // Back-to-back 5-bit frames.
        e.data = 9'h015; e.fe = 1'b0; e.pe = 1'b0; e.at = cyc + 6 + K5 * CPB + HALF;
        sb5.push_back(e);
        e.data = 9'h00A; e.at = e.at + 7 * CPB;
        sb5.push_back(e);
        fork
            begin
                drive(5, 9'h015, 5, 1'b0, 1'b0, 1'b1, 99);
                drive(5, 9'h00A, 5, 1'b0, 1'b0, 1'b1, 99);
            end
            begin
                check_pulse(5, at1);
                check_pulse(5, at2);
            end
        join
        chk("b2b_spacing", 32'(at2 - at1), 32'(7 * CPB));

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
